// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the multi-cycle core:
// opcodes, ALU ops, rd source selects and sequencer states.
package rv_pkg;

  localparam int RV_AW = 32;
  localparam int RV_DW = 32;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  typedef enum logic [3:0] {
    ALU_ZERO  = 4'h0,
    ALU_ADD   = 4'h1,
    ALU_SUB   = 4'h2,
    ALU_SLL   = 4'h3,
    ALU_SLT   = 4'h4,
    ALU_SLTU  = 4'h5,
    ALU_XOR   = 4'h6,
    ALU_SRL   = 4'h7,
    ALU_SRA   = 4'h8,
    ALU_OR    = 4'h9,
    ALU_AND   = 4'ha,
    ALU_PASSB = 4'hb
  } alu_op_e;

  typedef enum logic [1:0] {
    RD_ALU = 2'd0,
    RD_MEM = 2'd1,
    RD_PC4 = 2'd2
  } rd_sel_e;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } mc_state_e;

  typedef struct packed {
    logic lui;
    logic auipc;
    logic jal;
    logic jalr;
    logic branch;
    logic load;
    logic store;
    logic opimm;
    logic op;
  } opc_class_t;

  function automatic opc_class_t classify(
    input logic [6:0] opc
  );
    opc_class_t c;
    c        = '0;
    c.lui    = (opc == OPC_LUI);
    c.auipc  = (opc == OPC_AUIPC);
    c.jal    = (opc == OPC_JAL);
    c.jalr   = (opc == OPC_JALR);
    c.branch = (opc == OPC_BRANCH);
    c.load   = (opc == OPC_LOAD);
    c.store  = (opc == OPC_STORE);
    c.opimm  = (opc == OPC_OPIMM);
    c.op     = (opc == OPC_OP);
    return c;
  endfunction

  function automatic alu_op_e f3_to_alu(
    input logic [2:0] f3
  );
    alu_op_e r;
    case (f3)
      3'd0:    r = ALU_ADD;
      3'd1:    r = ALU_SLL;
      3'd2:    r = ALU_SLT;
      3'd3:    r = ALU_SLTU;
      3'd4:    r = ALU_XOR;
      3'd5:    r = ALU_SRL;
      3'd6:    r = ALU_OR;
      3'd7:    r = ALU_AND;
      default: r = ALU_ZERO;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation and operand-mux decode
// from opcode/func3/func7[5].
module alu_op_decode
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       func7_b5,
  output logic [3:0] alu_sel,
  output logic       rs1_pc_sel,
  output logic       rs2_imm_sel
);

  opc_class_t w_cls;
  alu_op_e    w_op;
  logic       w_alt_sra;

  assign w_cls     = classify(opcode);
  assign w_alt_sra = func7_b5 && (func3 == 3'd5);

  always_comb begin
    w_op        = ALU_ZERO;
    rs1_pc_sel  = 1'b0;
    rs2_imm_sel = 1'b0;
    unique case (1'b1)
      w_cls.op: begin
        w_op = f3_to_alu(func3);
        if (func7_b5 && (func3 == 3'd0))
          w_op = ALU_SUB;
        if (w_alt_sra)
          w_op = ALU_SRA;
      end
      // ADDI never becomes SUB: imm[10] is not an opcode bit
      w_cls.opimm: begin
        w_op        = f3_to_alu(func3);
        rs2_imm_sel = 1'b1;
        if (w_alt_sra)
          w_op = ALU_SRA;
      end
      w_cls.lui: begin
        w_op        = ALU_PASSB;
        rs2_imm_sel = 1'b1;
      end
      w_cls.auipc,
      w_cls.jal,
      w_cls.branch: begin
        w_op        = ALU_ADD;
        rs1_pc_sel  = 1'b1;
        rs2_imm_sel = 1'b1;
      end
      w_cls.jalr,
      w_cls.load,
      w_cls.store: begin
        w_op        = ALU_ADD;
        rs2_imm_sel = 1'b1;
      end
      default: ;
    endcase
  end

  assign alu_sel = w_op;

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM driving
// one shared req/ack memory port and all datapath enables.
module mc_sequencer
  import rv_pkg::*;
#(
  parameter int AW = RV_AW,
  parameter int DW = RV_DW
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       br_taken,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_en,
  output logic       pc_en,
  output logic       pc_sel,
  output logic       rf_en,
  output logic [3:0] alu_sel,
  output logic       rs1_pc_sel,
  output logic       rs2_imm_sel,
  output logic [1:0] rd_data_sel,
  output logic       retire,
  output logic       trap
);

  mc_state_e  r_state;
  mc_state_e  w_next;
  opc_class_t w_cls;
  logic       w_legal;
  logic       w_jump;
  logic [3:0] w_alu;
  logic       w_rs1_pc;
  logic       w_rs2_imm;
  logic       w_unused;

  assign w_cls    = classify(opcode);
  assign w_legal  = |w_cls;
  assign w_jump   = w_cls.jal | w_cls.jalr;
  assign w_unused = ^{func7[6], func7[4:0]}
                  ^ (AW != DW);

  alu_op_decode u_dec (
    .opcode      (opcode),
    .func3       (func3),
    .func7_b5    (func7[5]),
    .alu_sel     (w_alu),
    .rs1_pc_sel  (w_rs1_pc),
    .rs2_imm_sel (w_rs2_imm)
  );

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_FETCH;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_en       = 1'b0;
    pc_en       = 1'b0;
    pc_sel      = 1'b0;
    rf_en       = 1'b0;
    alu_sel     = ALU_ZERO;
    rs1_pc_sel  = 1'b0;
    rs2_imm_sel = 1'b0;
    rd_data_sel = RD_ALU;
    retire      = 1'b0;
    trap        = 1'b0;
    // reset overrides everything, including a pending ack
    if (!rst) begin
      unique case (r_state)
        S_FETCH: begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_en  = 1'b1;
            w_next = S_DECODE;
          end
        end
        S_DECODE: begin
          w_next = w_legal ? S_EXEC : S_TRAP;
        end
        S_EXEC: begin
          alu_sel     = w_alu;
          rs1_pc_sel  = w_rs1_pc;
          rs2_imm_sel = w_rs2_imm;
          unique case (1'b1)
            w_cls.load,
            w_cls.store: w_next = S_MEM;
            w_cls.branch: begin
              pc_en  = 1'b1;
              pc_sel = br_taken;
              retire = 1'b1;
              w_next = S_FETCH;
            end
            default: w_next = S_WB;
          endcase
        end
        S_MEM: begin
          alu_sel     = w_alu;
          rs1_pc_sel  = w_rs1_pc;
          rs2_imm_sel = w_rs2_imm;
          mem_req     = 1'b1;
          mem_we      = w_cls.store;
          if (mem_ack) begin
            if (w_cls.store) begin
              pc_en  = 1'b1;
              retire = 1'b1;
              w_next = S_FETCH;
            end else begin
              w_next = S_WB;
            end
          end
        end
        S_WB: begin
          alu_sel     = w_alu;
          rs1_pc_sel  = w_rs1_pc;
          rs2_imm_sel = w_rs2_imm;
          rf_en       = 1'b1;
          pc_en       = 1'b1;
          retire      = 1'b1;
          pc_sel      = w_jump;
          if (w_cls.load)
            rd_data_sel = RD_MEM;
          else if (w_jump)
            rd_data_sel = RD_PC4;
          w_next = S_FETCH;
        end
        S_TRAP: begin
          trap = 1'b1;
        end
        default: w_next = S_FETCH;
      endcase
    end
  end

endmodule
